// File: rtl/processador_multiciclo_hs.sv
`default_nettype none
// ============================================================================
//  Module   : processador_multiciclo_hs
//  Purpose  : Multicycle processor core with 8 GPRs (R7 = PC), A/G registers,
//             9-bit IR (III XXX YYY), load/store ISA and a req/ack memory port
//             that tolerates any number of wait cycles.
//  Options  : PROC_SLT_EN defined   -> opcode 111 is signed set-less-than
//             PROC_SLT_EN undefined -> opcode 111 is bitwise and
//  Debug    : State encoding IDLE=0 FETCH=1 DECODE=2 ALU=3 WB=4 MEM=5 DONE=6
//  Revision : 1.0 - initial release
// ============================================================================
module processador_multiciclo_hs #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int RESET_PC = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    output logic              Done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] BusWires,
    output logic [2:0]        State,
    output logic [DATA_W-1:0] Rx_data,
    output logic [DATA_W-1:0] Ry_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ALU    = 3'd3,
        S_WB     = 3'd4,
        S_MEM    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    localparam logic [DATA_W-1:0] PC_RST = DATA_W'(RESET_PC);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [8];
    logic [DATA_W-1:0]   regs_d [8];
    logic [DATA_W-1:0]   a_q, a_d, g_q, g_d;
    logic [8:0]          ir_q, ir_d;
    logic                done_q, done_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [2:0]          op, rx_sel, ry_sel;
    logic [DATA_W-1:0]   rx_val, ry_val, alu_res, bus, pc_inc;
    logic [ADDR_W-1:0]   pc_lo, pc_next_lo;

    assign op         = ir_q[8:6];
    assign rx_sel     = ir_q[5:3];
    assign ry_sel     = ir_q[2:0];
    assign rx_val     = regs_q[rx_sel];
    assign ry_val     = regs_q[ry_sel];
    assign pc_lo      = regs_q[7][ADDR_W-1:0];
    // PC increments wrap inside the address space; upper R7 bits are cleared
    assign pc_next_lo = pc_lo + ADDR_W'(1);
    assign pc_inc     = DATA_W'(pc_next_lo);

    // ALU datapath: A holds Rx, the second operand comes straight from Ry
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a_q + ry_val;
            OP_SUB:  alu_res = a_q - ry_val;
            default: begin
`ifdef PROC_SLT_EN
                alu_res = ($signed(a_q) < $signed(ry_val)) ? DATA_W'(1) : '0;
`else
                alu_res = a_q & ry_val;
`endif
            end
        endcase
    end

    // Next-state and next-register computation for the whole core
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
        a_d     = a_q;
        g_d     = g_q;
        ir_d    = ir_q;
        done_d  = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bus     = '0;
        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc_lo;
                end
            end
            S_FETCH: begin
                bus = mem_rdata;
                if (mem_ack) begin
                    ir_d      = mem_rdata[8:0];
                    regs_d[7] = pc_inc;
                    req_d     = 1'b0;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_MV, OP_MVNZ: begin
                        bus = ry_val;
                        if (op == OP_MV || g_q != '0) regs_d[rx_sel] = ry_val;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus     = rx_val;
                        a_d     = rx_val;
                        state_d = S_ALU;
                    end
                    OP_MVI: begin
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = pc_lo;
                        state_d = S_MEM;
                    end
                    OP_LD: begin
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = ry_val[ADDR_W-1:0];
                        state_d = S_MEM;
                    end
                    default: begin
                        bus     = rx_val;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = ry_val[ADDR_W-1:0];
                        wdata_d = rx_val;
                        state_d = S_MEM;
                    end
                endcase
            end
            S_ALU: begin
                bus     = ry_val;
                g_d     = alu_res;
                state_d = S_WB;
            end
            S_WB: begin
                bus            = g_q;
                regs_d[rx_sel] = g_q;
                done_d         = 1'b1;
                state_d        = S_DONE;
            end
            S_MEM: begin
                bus = we_q ? wdata_q : mem_rdata;
                if (mem_ack) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    // PC step first so an Rx=R7 load overrides it (jump)
                    if (op == OP_MVI) regs_d[7] = pc_inc;
                    if (op != OP_ST) regs_d[rx_sel] = mem_rdata;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight request at once
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 7; i++) regs_q[i] <= '0;
            regs_q[7] <= PC_RST;
            a_q     <= '0;
            g_q     <= '0;
            ir_q    <= '0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
            a_q     <= a_d;
            g_q     <= g_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign Done      = done_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign BusWires  = bus;
    assign State     = state_q;
    assign Rx_data   = rx_val;
    assign Ry_data   = ry_val;

endmodule
`default_nettype wire

// File: tb/tb_processador_multiciclo_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_processador_multiciclo_hs
//  Purpose  : Self-checking bench for processador_multiciclo_hs: directed
//             program steps followed by random instructions and random memory
//             wait counts, compared against an instruction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_processador_multiciclo_hs;

    localparam logic [2:0] MV = 3'd0, MVI = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] LD = 3'd4, ST = 3'd5, MVNZ = 3'd6, OP7 = 3'd7;

    logic        clk = 1'b0;
    logic        Reset, Run;
    logic        Done, mem_req, mem_we, mem_ack;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata, BusWires, Rx_data, Ry_data;
    logic [2:0]  State;

    processador_multiciclo_hs #(.DATA_W(16), .ADDR_W(6), .RESET_PC(0)) dut (
        .Clock(clk), .Reset(Reset), .Run(Run), .Done(Done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .BusWires(BusWires), .State(State), .Rx_data(Rx_data), .Ry_data(Ry_data)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;

    // Environment memory plus reference architectural state
    logic [15:0] mem [64];
    logic [15:0] m_r [8];
    logic [15:0] m_g;
    int          wait_q [$];

    // Memory responder bookkeeping
    bit          txn_busy = 1'b0;
    bit          txn_stable;
    bit          txn_we;
    int          txn_need, txn_cnt, txn_cycles;
    logic [5:0]  txn_addr;
    logic [15:0] txn_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory side: acks after the queued wait count, random ack noise when idle
    always @(negedge clk) begin
        if (mem_req) begin
            if (!txn_busy) begin
                txn_busy   = 1'b1;
                txn_need   = 0;
                if (wait_q.size() > 0) txn_need = wait_q.pop_front();
                txn_cnt    = 0;
                txn_cycles = 0;
                txn_stable = 1'b1;
                txn_addr   = mem_addr;
                txn_we     = mem_we;
                txn_wdata  = mem_wdata;
            end else if (mem_addr !== txn_addr || mem_we !== txn_we ||
                         (txn_we && mem_wdata !== txn_wdata)) begin
                txn_stable = 1'b0;
            end
            txn_cycles++;
            if (txn_cnt == txn_need) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we) mem[mem_addr] = mem_wdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                txn_cnt++;
            end
        end else begin
            txn_busy  = 1'b0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
        end
    end

    // Place one instruction at the model PC, predict its effect, run and compare
    task automatic run_instr(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                             input logic [15:0] imm, input int wf, input int wm);
        logic [5:0]  pc, maddr;
        logic [15:0] rxo, ryo, res, prev_bus;
        bit          is_mem, is_alu;
        int          exp_lat, lat;
        pc     = m_r[7][5:0];
        maddr  = '0;
        mem[pc] = {7'd0, op, x, y};
        if (op == MVI) mem[pc + 6'd1] = imm;
        is_mem = (op == MVI || op == LD || op == ST);
        is_alu = (op == ADD || op == SUB || op == OP7);
        wait_q.push_back(wf);
        if (is_mem) wait_q.push_back(wm);
        exp_lat = (is_mem ? 4 : (is_alu ? 5 : 3)) + wf + (is_mem ? wm : 0);

        m_r[7] = {10'd0, pc + 6'd1};
        rxo = m_r[x];
        ryo = m_r[y];
        case (op)
            MV:   m_r[x] = ryo;
            MVI:  begin m_r[7] = {10'd0, pc + 6'd2}; m_r[x] = imm; end
            ADD:  begin res = rxo + ryo; m_g = res; m_r[x] = res; end
            SUB:  begin res = rxo - ryo; m_g = res; m_r[x] = res; end
            LD:   begin maddr = ryo[5:0]; m_r[x] = mem[maddr]; end
            ST:   maddr = ryo[5:0];
            MVNZ: if (m_g != 16'd0) m_r[x] = ryo;
            default: begin
`ifdef PROC_SLT_EN
                res = ($signed(rxo) < $signed(ryo)) ? 16'd1 : 16'd0;
`else
                res = rxo & ryo;
`endif
                m_g = res;
                m_r[x] = res;
            end
        endcase

        @(negedge clk);
        Run = 1'b1;
        @(posedge clk);
        #1;
        Run = 1'b0;
        check("fetch_req", mem_req, 1);
        check("fetch_we", mem_we, 0);
        check("fetch_addr", mem_addr, pc);
        lat = 1;
        prev_bus = BusWires;
        while (Done !== 1'b1 && lat < 100) begin
            prev_bus = BusWires;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rx_result", Rx_data, m_r[x]);
        if (is_alu) check("g_on_bus", prev_bus, m_g);
        if (op == ST) begin
            check("st_data", mem[maddr], rxo);
            check("st_we", txn_we, 1);
            check("st_stable", txn_stable, 1);
            check("st_req_cycles", txn_cycles, wm + 1);
        end
        @(posedge clk);
        #1;
        check("done_pulse", Done, 0);
        check("back_idle", State, 0);
    endtask

    initial begin
        logic [2:0] rop, rx, ry;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_g       = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        Run       = 1'b0;
        Reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", State, 0);
        check("rst_done", Done, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_r0", Rx_data, 0);
        @(negedge clk);
        Reset = 1'b0;

        // Directed program
        run_instr(MVI, 3'd0, 3'd0, 16'h0005, 0, 0);
        run_instr(MVI, 3'd1, 3'd0, 16'h0003, 0, 0);
        run_instr(ADD, 3'd0, 3'd1, 16'h0000, 0, 0);
        run_instr(SUB, 3'd0, 3'd1, 16'h0000, 0, 0);
        run_instr(MVI, 3'd2, 3'd0, 16'hFFFF, 0, 0);
        run_instr(MVI, 3'd3, 3'd0, 16'h0001, 0, 0);
        run_instr(MVI, 3'd4, 3'd0, 16'h0077, 1, 1);
        run_instr(ADD, 3'd2, 3'd3, 16'h0000, 0, 0);
        run_instr(MVNZ, 3'd4, 3'd3, 16'h0000, 0, 0);
        run_instr(MVI, 3'd1, 3'd0, 16'h1234, 0, 0);
        run_instr(MVI, 3'd2, 3'd0, 16'h000A, 0, 0);
        run_instr(ST, 3'd1, 3'd2, 16'h0000, 0, 3);
        run_instr(LD, 3'd3, 3'd2, 16'h0000, 1, 2);
        run_instr(MVI, 3'd5, 3'd0, 16'hFFFF, 0, 0);
        run_instr(MVI, 3'd6, 3'd0, 16'h0001, 0, 0);
        run_instr(OP7, 3'd5, 3'd6, 16'h0000, 0, 0);
        run_instr(MV, 3'd7, 3'd5, 16'h0000, 0, 0);
        run_instr(MVNZ, 3'd4, 3'd6, 16'h0000, 2, 0);
        run_instr(MV, 3'd0, 3'd7, 16'h0000, 0, 0);

        // Reset in the middle of a stalled fetch
        wait_q.push_back(6);
        @(negedge clk);
        Run = 1'b1;
        @(posedge clk);
        #1;
        Run = 1'b0;
        check("midrst_req_before", mem_req, 1);
        @(posedge clk);
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_req", mem_req, 0);
        check("midrst_state", State, 0);
        check("midrst_done", Done, 0);
        check("midrst_addr", mem_addr, 0);
        @(negedge clk);
        Reset = 1'b0;
        wait_q.delete();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_g = '0;
        run_instr(MV, 3'd0, 3'd0, 16'h0000, 0, 0);

        // Random instructions with random wait counts
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            rx  = 3'($urandom_range(0, 7));
            ry  = 3'($urandom_range(0, 7));
            run_instr(rop, rx, ry, 16'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
